bcd_seq_convert: RTL and testbench

Sequential binary-to-BCD converter controller. It accepts a WIDTH-bit binary operand on a start strobe and runs the shift-and-add-3 algorithm (double dabble), one bit per clock. It drives a start/busy/done handshake and holds the packed BCD result until the next conversion completes. It is the clocked, width-scalable successor to the 4-bit combinational binary-to-BCD converter, and sits between arithmetic results and the BCD/seven-segment display path.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_add3_digit.sv | 11 +
 rtl/bcd_seq_convert.sv | 121 ++++++++++++
 tb/tb_bcd_seq_convert.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Smallest digit count whose decimal range covers every width-bit value.
  function automatic int min_digits(input int width);
    longint maxv;
    longint pow10;
    int     d;
    maxv  = (longint'(1) << width) - 1;
    pow10 = 10;
    d     = 1;
    while (pow10 <= maxv) begin
      pow10 = pow10 * 10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(ADD3_THRESH)) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/bcd_seq_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional leading-zero mask output enabled by defining BCD_SEQ_BLANK_EN.
module bcd_seq_convert
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
`ifdef BCD_SEQ_BLANK_EN
  output logic [DIGITS-1:0]             blank,
`endif
  output state_t                        state_dbg
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("bcd_seq_convert: WIDTH must be within 4..16");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bcd_seq_convert: DIGITS too small for WIDTH");
  end

  // Handshake: start is sampled only in IDLE (busy=0, done=0); busy is high
  // for the WIDTH shift cycles; done pulses once with bcd already valid.
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   dig;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   dig_shift;
  logic [WIDTH-1:0] opnd;
  logic            unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (dig[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits shift left, pulling in the operand MSB; the top bit
  // falls off and is always zero when DIGITS is large enough.
  assign dig_shift      = {adj[BW-2:0], opnd[WIDTH-1]};
  assign unused_adj_msb = adj[BW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              zero_run;

  always_comb begin
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (dig_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_nxt[i] = zero_run;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dig  <= '0;
      opnd <= '0;
      bcd  <= '0;
`ifdef BCD_SEQ_BLANK_EN
      blank <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opnd <= bin;
            dig  <= '0;
            cnt  <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          dig  <= dig_shift;
          opnd <= opnd << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd <= dig_shift;
`ifdef BCD_SEQ_BLANK_EN
            blank <= blank_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Self-checking bench for bcd_seq_convert (WIDTH=8, DIGITS=3).
module tb_bcd_seq_convert;
  import bcd_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  bin = '0;
  logic          busy;
  logic          done;
  logic [4*D-1:0] bcd;
  state_t        state_dbg;
`ifdef BCD_SEQ_BLANK_EN
  logic [D-1:0]  blank;
`endif

  bcd_seq_convert #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
`ifdef BCD_SEQ_BLANK_EN
    .blank     (blank),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [11:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal digits by plain division.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
    return {v < 100, v < 10, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (mon_en && done) begin
      done_seen++;
      check("stream_expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("stream_bcd", 32'(bcd), 32'(exp_q.pop_front()));
      check("stream_busy_done_overlap", 32'(busy), 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic run_conv(input logic [W-1:0] v, input logic [11:0] exp_bcd);
    int waited;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = W'($urandom_range(0, 255));
    waited   = 0;
    busy_cnt = 0;
    while (!done && waited < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      waited++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(waited), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("busy_in_done", 32'(busy), 32'd0);
    check("bcd", 32'(bcd), 32'(exp_bcd));
`ifdef BCD_SEQ_BLANK_EN
    check("blank_model", 32'(blank), 32'(ref_blank(int'(v))));
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("back_to_idle", 32'(state_dbg), 32'(IDLE));
    check("bcd_held", 32'(bcd), 32'(exp_bcd));
  endtask

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp_bcd;
    logic [2:0]  exp_blank;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    int bad_done;
    int bad_bcd;
    int bad_state;

    tbl[0] = '{8'd0,   12'h000, 3'b110};
    tbl[1] = '{8'd255, 12'h255, 3'b000};
    tbl[2] = '{8'd99,  12'h099, 3'b100};
    tbl[3] = '{8'd100, 12'h100, 3'b000};
    tbl[4] = '{8'd7,   12'h007, 3'b110};
    tbl[5] = '{8'd42,  12'h042, 3'b100};
    tbl[6] = '{8'd123, 12'h123, 3'b000};

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
`ifdef BCD_SEQ_BLANK_EN
    check("rst_blank", 32'(blank), 32'b111);
`endif
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 7; i++) begin
      run_conv(tbl[i].bin, tbl[i].exp_bcd);
`ifdef BCD_SEQ_BLANK_EN
      check("tbl_blank", 32'(blank), 32'(tbl[i].exp_blank));
`endif
    end

    // exhaustive against the model, then random order
    for (int v = 0; v < 256; v++) run_conv(W'(v), ref_bcd(v));
    for (int i = 0; i < 20; i++) begin
      n = int'($urandom_range(0, 255));
      run_conv(W'(n), ref_bcd(n));
    end

    // start held high, bin changing every cycle: acceptance every W+2 cycles
    done_seen = 0;
    mon_en    = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b1;
      bin   = W'($urandom_range(0, 255));
      if (k % (W + 2) == 0) exp_q.push_back(ref_bcd(int'(bin)));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    mon_en = 1'b0;
    check("stream_done_count", 32'(done_seen), 32'd5);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // start pulsed during SHIFT is ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ign_done_seen", 32'(done), 32'd1);
    check("ign_bcd", 32'(bcd), 32'h042);
    @(negedge clk);
    check("ign_idle", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    check("ign_no_restart", 32'(busy), 32'd0);
    run_conv(8'd7, 12'h007);

    // reset mid-conversion discards the operation
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_done  = 0;
    bad_bcd   = 0;
    bad_state = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) bad_done++;
      if (bcd !== 12'h000) bad_bcd++;
      if (state_dbg !== IDLE) bad_state++;
    end
    check("mid_no_done", 32'(bad_done), 32'd0);
    check("mid_bcd_zero", 32'(bad_bcd), 32'd0);
    check("mid_stays_idle", 32'(bad_state), 32'd0);
    run_conv(8'd200, 12'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
